instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting directly upstream of the opcode controller. Holds the program counter and runs a single-outstanding request/valid transaction to instruction memory. Registers each returned 32-bit word into a one-entry IF/ID output slot with a valid/ready handshake. Splits the word into the opcode, register, shamt and immediate fields that the controller and register file consume.

## Interface
- ADDR_W, 32, PC and instruction-memory address width
- RESET_PC, 0, PC value loaded on reset
- PC_STEP, 4, PC increment per fetched word
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  fetch enable; new requests are issued only while high
- imem_req  out  1  request, level, held until imem_valid
- imem_addr  out  ADDR_W  fetch address, equals pc while imem_req=1
- imem_rdata  in  32  instruction word, sampled when imem_valid=1
- imem_valid  in  1  completes the outstanding request; ignored when imem_req=0
- id_valid  out  1  output slot holds an instruction
- id_ready  in  1  downstream accepts slot this cycle
- id_instr  out  32  registered instruction word
- id_pc  out  ADDR_W  address the word was fetched from
- id_opcode  out  6  id_instr[31:26]
- id_rs  out  5  id_instr[25:21]
- id_rt  out  5  id_instr[20:16]
- id_rd  out  5  id_instr[15:11]
- id_shamt  out  5  id_instr[10:6]
- id_imm  out  16  id_instr[15:0]
- halted  out  1  fetch stopped on halt word (0 when halt feature compiled out)

## Operation
- Reset (async, rst_n=0): pc=RESET_PC, state IDLE, imem_req=0, id_valid=0, id_instr=0, id_pc=0, halted=0; all field outputs 0.
- States: IDLE, WAIT, HALT (HALT present only with the macro).
- IDLE -> WAIT when en=1 and slot free (id_valid=0, or id_valid=1 with id_ready=1 this cycle). Otherwise remain IDLE.
- WAIT: imem_req=1, imem_addr=pc, both stable. Remain until imem_valid=1.
- On the imem_valid cycle, at the closing edge:
  - id_instr=imem_rdata, id_pc=pc, id_valid=1
  - pc=pc+PC_STEP, modulo 2^ADDR_W; wraps from all-ones region to 0
  - go to IDLE
- Overflow of the slot is impossible: a request starts only when the slot is free.
- Handshake: id_valid && id_ready at an edge clears id_valid unless a capture happens at that edge. While id_valid=1 and id_ready=0, all id_* outputs hold.
- en dropping during WAIT: outstanding fetch completes normally, then the block stays IDLE.
- Field outputs are pure slices of id_instr.

## Timing
- imem_req is registered: it rises the cycle after the IDLE->WAIT decision.
- Memory returns imem_valid 1 or more cycles after imem_req rises, never in the same cycle.
- Minimum case (1-cycle memory, id_ready held 1):
  - cycle 0: IDLE
  - cycle 1: req
  - cycle 2: valid
  - cycle 3: id_valid=1, next IDLE decision
- Throughput is one instruction per 3 cycles at minimum.
- Reset asserted mid-WAIT aborts the fetch. A late imem_valid arriving after reset is ignored because imem_req=0.

## Configuration
- FETCH_HALT_EN defined:
  - A captured word equal to 32'h0000_0000 is not loaded into the slot; id_valid is unchanged.
  - pc does not advance.
  - State goes to HALT; halted=1 from the next cycle.
  - HALT is left only by reset.
- FETCH_HALT_EN undefined:
  - A zero word is forwarded like any other (the controller decodes it as default, all controls 0).
  - halted is tied 0.

## Structure
- Shared package mips_pkg:
  - OPCODE_W=6, REG_W=5, IMM_W=16
  - field bit positions
  - HALT_WORD=32'h0
  - fetch state encoding
- One sub-module, pc_reg: async-reset PC register with load-enable increment by PC_STEP.

## Test plan
- Reset then en=1, 1-cycle memory returning 32'h0420_1800 at addr 0, id_ready=1 -> id_valid in cycle 3, id_opcode=6'b000001, id_rs=1, id_rt=0, id_rd=3, id_pc=0, next imem_addr=4.
- id_ready=0 for 5 cycles after first capture -> imem_req stays 0, id_instr stable. id_ready=1 -> next request issued the following cycle.
- Memory latency 4 cycles -> imem_addr stable throughout WAIT, exactly one capture per request.
- RESET_PC=32'hFFFF_FFFC, one fetch -> pc wraps to 0, id_pc=32'hFFFF_FFFC.
- rst_n pulsed low during WAIT, then imem_valid=1 -> no capture, id_valid=0, pc=RESET_PC.
- Zero word at addr 8 -> with FETCH_HALT_EN: halted=1, no new id_valid, imem_req stays 0. Without FETCH_HALT_EN: id_valid=1, id_opcode=0, fetch continues at 12.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS-style instruction field layout, halt word and fetch FSM encoding.
// Used by the fetch stage and, downstream, by the opcode controller and register file.
package mips_pkg;

   localparam int INSTR_W  = 32;
   localparam int OPCODE_W = 6;
   localparam int REG_W    = 5;
   localparam int SHAMT_W  = 5;
   localparam int IMM_W    = 16;

   localparam int OPCODE_LSB = 26;
   localparam int RS_LSB     = 21;
   localparam int RT_LSB     = 16;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_LSB  = 6;
   localparam int IMM_LSB    = 0;

   localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_WAIT = 2'd1,
      FETCH_HALT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [REG_W-1:0]    rs;
      logic [REG_W-1:0]    rt;
      logic [REG_W-1:0]    rd;
      logic [SHAMT_W-1:0]  shamt;
      logic [IMM_W-1:0]    imm;
   } instr_fields_t;

   // rd/shamt overlap imm: every view is a plain slice of the same word
   function automatic instr_fields_t decode_fields(input logic [INSTR_W-1:0] instr);
      instr_fields_t f;
      f.opcode = instr[OPCODE_LSB +: OPCODE_W];
      f.rs     = instr[RS_LSB     +: REG_W];
      f.rt     = instr[RT_LSB     +: REG_W];
      f.rd     = instr[RD_LSB     +: REG_W];
      f.shamt  = instr[SHAMT_LSB  +: SHAMT_W];
      f.imm    = instr[IMM_LSB    +: IMM_W];
      return f;
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: loads RESET_PC on async reset, advances by PC_STEP when inc is high.
// Addition wraps modulo 2^ADDR_W.
module pc_reg #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (inc) begin
         pc <= pc + STEP;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding imem request, one-entry IF/ID slot.
// Optional halt-on-zero-word behaviour is compiled in with FETCH_HALT_EN.
module instr_fetch
   import mips_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                imem_valid,
   output logic                id_valid,
   input  logic                id_ready,
   output logic [INSTR_W-1:0]  id_instr,
   output logic [ADDR_W-1:0]   id_pc,
   output logic [OPCODE_W-1:0] id_opcode,
   output logic [REG_W-1:0]    id_rs,
   output logic [REG_W-1:0]    id_rt,
   output logic [REG_W-1:0]    id_rd,
   output logic [SHAMT_W-1:0]  id_shamt,
   output logic [IMM_W-1:0]    id_imm,
   output logic                halted
);

   fetch_state_e      state;
   fetch_state_e      state_nxt;
   logic [ADDR_W-1:0] pc;
   logic              slot_free;
   logic              is_halt_word;
   logic              capture;
   instr_fields_t     fields;

   // A request may only start if the slot will be empty at the launching edge
   assign slot_free = !id_valid || id_ready;

`ifdef FETCH_HALT_EN
   assign is_halt_word = (imem_rdata == HALT_WORD);
`else
   assign is_halt_word = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FETCH_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         FETCH_IDLE: begin
            if (en && slot_free) begin
               state_nxt = FETCH_WAIT;
            end
         end
         FETCH_WAIT: begin
            if (imem_valid) begin
               state_nxt = is_halt_word ? FETCH_HALT : FETCH_IDLE;
            end
         end
`ifdef FETCH_HALT_EN
         FETCH_HALT: state_nxt = FETCH_HALT;
`endif
         default:    state_nxt = FETCH_IDLE;
      endcase
   end

   always_comb begin
      imem_req = 1'b0;
      capture  = 1'b0;
      halted   = 1'b0;
      unique case (state)
         FETCH_WAIT: begin
            imem_req = 1'b1;
            capture  = imem_valid && !is_halt_word;
         end
`ifdef FETCH_HALT_EN
         FETCH_HALT: halted = 1'b1;
`endif
         default: ;
      endcase
   end

   assign imem_addr = pc;

   pc_reg #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (capture),
      .pc    (pc)
   );

   // IF/ID slot: capture wins over a simultaneous downstream accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid <= 1'b0;
         id_instr <= '0;
         id_pc    <= '0;
      end else if (capture) begin
         id_valid <= 1'b1;
         id_instr <= imem_rdata;
         id_pc    <= pc;
      end else if (id_ready) begin
         id_valid <= 1'b0;
      end
   end

   assign fields    = decode_fields(id_instr);
   assign id_opcode = fields.opcode;
   assign id_rs     = fields.rs;
   assign id_rt     = fields.rt;
   assign id_rd     = fields.rd;
   assign id_shamt  = fields.shamt;
   assign id_imm    = fields.imm;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed stimulus, a queue-based fetch model checked every cycle,
// and literal expectations for the key scenarios (also covers the FETCH_HALT_EN build).
module tb_instr_fetch;

   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

   logic        clk = 1'b0;
   logic        rst_n, en, imem_req, imem_valid, id_valid, id_ready, halted;
   logic [31:0] imem_addr, imem_rdata, id_instr, id_pc;
   logic [5:0]  id_opcode;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic [15:0] id_imm;

   logic        w_en, w_req, w_valid, w_id_valid, w_id_ready, w_halted;
   logic [31:0] w_addr, w_rdata, w_id_instr, w_id_pc;
   logic [5:0]  w_opcode;
   logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
   logic [15:0] w_imm;

   int m_cmp = 0, m_bad = 0, c_cmp = 0, c_bad = 0;
   int mem_lat = 1;
   bit mem_auto = 1'b1;
   bit force_valid = 1'b0;

   logic [31:0] q_pc[$];
   logic [31:0] q_word[$];
   logic [31:0] fetch_pc = 32'h0;
   bit          exp_halted = 1'b0;

   always #5 clk = ~clk;

   instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid), .id_valid(id_valid),
      .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
      .id_imm(id_imm), .halted(halted)
   );

   instr_fetch #(.ADDR_W(32), .RESET_PC(WRAP_PC), .PC_STEP(4)) u_wrap (
      .clk(clk), .rst_n(rst_n), .en(w_en), .imem_req(w_req), .imem_addr(w_addr),
      .imem_rdata(w_rdata), .imem_valid(w_valid), .id_valid(w_id_valid),
      .id_ready(w_id_ready), .id_instr(w_id_instr), .id_pc(w_id_pc), .id_opcode(w_opcode),
      .id_rs(w_rs), .id_rt(w_rt), .id_rd(w_rd), .id_shamt(w_shamt),
      .id_imm(w_imm), .halted(w_halted)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0420_1800;
      if (a == 32'h8) return 32'h0000_0000;
      return 32'h8C00_0000 | a;
   endfunction

   task automatic chk_m(input string name, input logic [63:0] act, input logic [63:0] exp);
      m_cmp++;
      if (act !== exp) begin
         m_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_c(input string name, input logic [63:0] act, input logic [63:0] exp);
      c_cmp++;
      if (act !== exp) begin
         c_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory responder: valid mem_lat cycles after the request rises, or manual override
   initial begin
      int cnt;
      cnt        = 0;
      imem_valid = 1'b0;
      imem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         if (!mem_auto) begin
            imem_valid = force_valid;
            imem_rdata = force_valid ? 32'hDEAD_BEEF : 32'h0;
            cnt        = 0;
         end else if (imem_valid) begin
            imem_valid = 1'b0;
            cnt        = 0;
         end else if (imem_req) begin
            cnt++;
            if (cnt > mem_lat) begin
               imem_valid = 1'b1;
               imem_rdata = mem_word(imem_addr);
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Model: addresses are fetched in order RESET_PC, +4, ...; each completed fetch
   // enters a one-deep queue that must be visible on id_* until accepted.
   initial begin
      logic [31:0] w;
      bit          halt_hit;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk_c("rst_id_valid", id_valid, 0);
            chk_c("rst_imem_req", imem_req, 0);
            chk_c("rst_halted", halted, 0);
            chk_c("rst_id_instr", id_instr, 0);
            chk_c("rst_id_pc", id_pc, 0);
            chk_c("rst_imem_addr", imem_addr, 0);
            q_pc.delete();
            q_word.delete();
            fetch_pc   = 32'h0;
            exp_halted = 1'b0;
         end else begin
            chk_c("halted", halted, exp_halted);
            if (exp_halted) chk_c("halt_req", imem_req, 0);
            chk_c("id_valid", id_valid, q_pc.size() != 0);
            if (q_pc.size() != 0) begin
               w = q_word[0];
               chk_c("id_instr", id_instr, w);
               chk_c("id_pc", id_pc, q_pc[0]);
               chk_c("id_opcode", id_opcode, (w >> 26) & 32'h3F);
               chk_c("id_rs", id_rs, (w >> 21) & 32'h1F);
               chk_c("id_rt", id_rt, (w >> 16) & 32'h1F);
               chk_c("id_rd", id_rd, (w >> 11) & 32'h1F);
               chk_c("id_shamt", id_shamt, (w >> 6) & 32'h1F);
               chk_c("id_imm", id_imm, w % 32'h1_0000);
               if (id_ready) begin
                  void'(q_pc.pop_front());
                  void'(q_word.pop_front());
               end
            end
            if (imem_req) begin
               chk_c("req_slot_free", q_pc.size(), 0);
               chk_c("imem_addr", imem_addr, fetch_pc);
               if (imem_valid) begin
                  halt_hit = 1'b0;
`ifdef FETCH_HALT_EN
                  halt_hit = (imem_rdata == 32'h0);
`endif
                  if (halt_hit) begin
                     exp_halted = 1'b1;
                  end else begin
                     q_pc.push_back(fetch_pc);
                     q_word.push_back(imem_rdata);
                     fetch_pc = fetch_pc + 32'd4;
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int req_cycles, caps;
      rst_n = 1'b0; en = 1'b0; id_ready = 1'b0;
      w_en = 1'b0; w_id_ready = 1'b1; w_valid = 1'b0; w_rdata = 32'h0;
      repeat (2) @(negedge clk);
      chk_m("reset_req", imem_req, 0);
      chk_m("reset_id_valid", id_valid, 0);
      chk_m("reset_addr", imem_addr, 0);
      chk_m("reset_wrap_addr", w_addr, WRAP_PC);

      // Minimum-latency fetch of 0x04201800 at address 0
      @(posedge clk); #1; rst_n = 1'b1; en = 1'b1; id_ready = 1'b1;
      @(negedge clk); chk_m("c0_req", imem_req, 0);
      @(negedge clk); chk_m("c1_req", imem_req, 1); chk_m("c1_addr", imem_addr, 0);
      @(negedge clk); chk_m("c2_id_valid", id_valid, 0);
      @(negedge clk);
      chk_m("c3_id_valid", id_valid, 1);
      chk_m("c3_id_instr", id_instr, 32'h0420_1800);
      chk_m("c3_opcode", id_opcode, 6'b000001);
      chk_m("c3_rs", id_rs, 1);
      chk_m("c3_rt", id_rt, 0);
      chk_m("c3_rd", id_rd, 3);
      chk_m("c3_imm", id_imm, 16'h1800);
      chk_m("c3_id_pc", id_pc, 0);
      @(posedge clk); #1; id_ready = 1'b0;
      @(negedge clk); chk_m("c4_req", imem_req, 1); chk_m("c4_addr", imem_addr, 4);

      // Back-pressure: slot held, no new request
      for (int i = 0; i < 20 && !id_valid; i++) @(negedge clk);
      chk_m("held_seen", id_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_m("held_req", imem_req, 0);
         chk_m("held_valid", id_valid, 1);
         chk_m("held_instr", id_instr, 32'h8C00_0004);
      end
      @(posedge clk); #1; id_ready = 1'b1;
      @(negedge clk); chk_m("release_req0", imem_req, 0);
      @(negedge clk); chk_m("release_req1", imem_req, 1); chk_m("release_addr", imem_addr, 8);

      // Zero word at address 8
`ifdef FETCH_HALT_EN
      repeat (8) @(negedge clk);
      chk_m("zero_halted", halted, 1);
      chk_m("zero_id_valid", id_valid, 0);
      chk_m("zero_req", imem_req, 0);
      chk_m("zero_pc_hold", imem_addr, 8);
`else
      for (int i = 0; i < 20 && !id_valid; i++) @(negedge clk);
      chk_m("zero_valid", id_valid, 1);
      chk_m("zero_instr", id_instr, 0);
      chk_m("zero_opcode", id_opcode, 0);
      chk_m("zero_pc", id_pc, 8);
      chk_m("zero_halted", halted, 0);
      for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
      chk_m("after_zero_req", imem_req, 1);
      chk_m("after_zero_addr", imem_addr, 12);
`endif

      // Reset, then a 4-cycle memory with en dropped during WAIT
      @(posedge clk); #1; rst_n = 1'b0; en = 1'b0; mem_lat = 4;
      @(negedge clk);
      @(posedge clk); #1; rst_n = 1'b1; en = 1'b1;
      for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
      chk_m("lat_req_seen", imem_req, 1);
      chk_m("lat_addr", imem_addr, 0);
      @(posedge clk); #1; en = 1'b0;
      req_cycles = 1;
      caps = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (imem_req) req_cycles++;
         if (id_valid) begin
            caps++;
            chk_m("lat_id_instr", id_instr, 32'h0420_1800);
         end
      end
      chk_m("lat_req_cycles", req_cycles, 5);
      chk_m("lat_captures", caps, 1);

      // Reset during WAIT, followed by a stray imem_valid
      @(posedge clk); #1; en = 1'b1;
      for (int i = 0; i < 20 && !imem_req; i++) @(negedge clk);
      chk_m("abort_req_seen", imem_req, 1);
      chk_m("abort_addr", imem_addr, 4);
      @(posedge clk); #1; mem_auto = 1'b0; en = 1'b0;
      @(posedge clk); #1; rst_n = 1'b0;
      @(negedge clk); chk_m("abort_req", imem_req, 0); chk_m("abort_valid", id_valid, 0);
      @(posedge clk); #1; rst_n = 1'b1; force_valid = 1'b1;
      @(negedge clk); chk_m("late_req", imem_req, 0);
      @(posedge clk); #1; force_valid = 1'b0; mem_auto = 1'b1;
      @(negedge clk);
      chk_m("late_id_valid", id_valid, 0);
      chk_m("late_addr", imem_addr, 0);
      chk_m("late_req_after", imem_req, 0);

      // PC wrap from 0xFFFFFFFC
      @(posedge clk); #1; w_en = 1'b1;
      for (int i = 0; i < 20 && !w_req; i++) @(negedge clk);
      chk_m("wrap_req", w_req, 1);
      chk_m("wrap_addr", w_addr, WRAP_PC);
      @(posedge clk); #1; w_valid = 1'b1; w_rdata = 32'h2108_0020; w_en = 1'b0;
      @(posedge clk); #1; w_valid = 1'b0;
      @(negedge clk);
      chk_m("wrap_id_valid", w_id_valid, 1);
      chk_m("wrap_id_pc", w_id_pc, WRAP_PC);
      chk_m("wrap_id_instr", w_id_instr, 32'h2108_0020);
      chk_m("wrap_opcode", w_opcode, 8);
      chk_m("wrap_rs", w_rs, 8);
      chk_m("wrap_rt", w_rt, 8);
      chk_m("wrap_imm", w_imm, 16'h0020);
      chk_m("wrap_pc_zero", w_addr, 0);
      chk_m("wrap_req_done", w_req, 0);
      chk_m("wrap_halted", w_halted, 0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", m_cmp + c_cmp, m_bad + c_bad);
      $finish;
   end

endmodule
